// File: rtl/l2_bus_ctrl_if.sv
// ---------------------------------------------------------------------------
// l2_bus_ctrl_if
// Bundles every handshake and bus signal of the L2 downstream bus engine.
//   Request  : req_valid/req_ready/req_op/req_addr  (L2 controller -> engine)
//   Response : resp_valid/resp_ready/resp_snoop/resp_err (engine -> L2)
//   Sys bus  : bus_req/bus_gnt/bus_addr_valid/bus_op/bus_addr
//   Snoop    : snoop_hit/snoop_hitm (peer caches -> engine)
//   Memory   : mem_ack
//   Status   : retry_cnt (saturating HITM retry count)
// Modports: slave = the engine, master = the surrounding environment.
// ---------------------------------------------------------------------------
interface l2_bus_ctrl_if #(
    parameter int ADD_SIZE = 32
) ();
    logic                req_valid;
    logic                req_ready;
    logic [1:0]          req_op;
    logic [ADD_SIZE-1:0] req_addr;
    logic                resp_valid;
    logic                resp_ready;
    logic [1:0]          resp_snoop;
    logic                resp_err;
    logic                bus_req;
    logic                bus_gnt;
    logic                bus_addr_valid;
    logic [1:0]          bus_op;
    logic [ADD_SIZE-1:0] bus_addr;
    logic                snoop_hit;
    logic                snoop_hitm;
    logic                mem_ack;
    logic [7:0]          retry_cnt;

    modport master (
        output req_valid, req_op, req_addr, resp_ready, bus_gnt,
               snoop_hit, snoop_hitm, mem_ack,
        input  req_ready, resp_valid, resp_snoop, resp_err, bus_req,
               bus_addr_valid, bus_op, bus_addr, retry_cnt
    );

    modport slave (
        input  req_valid, req_op, req_addr, resp_ready, bus_gnt,
               snoop_hit, snoop_hitm, mem_ack,
        output req_ready, resp_valid, resp_snoop, resp_err, bus_req,
               bus_addr_valid, bus_op, bus_addr, retry_cnt
    );
endinterface

// File: rtl/l2_bus_ctrl.sv
// ---------------------------------------------------------------------------
// l2_bus_ctrl
// Downstream bus-operation engine for the L2 cache. Takes one line request
// (READ / WRITE / INVALIDATE / RWIM), arbitrates for the system bus, issues
// the line address, gathers snoop responses over a fixed window, runs the
// memory data phase and returns one response with merged snoop + error flag.
// Ports:
//   i_clk   : clock, rising edge
//   i_reset : asynchronous active-high reset
//   io_bus  : l2_bus_ctrl_if.slave (request, response, bus, snoop, memory,
//             retry counter)
// All outputs are registered and change together with the state register.
// ---------------------------------------------------------------------------
module l2_bus_ctrl #(
    parameter int ADD_SIZE    = 32,
    parameter int OFFSET_SIZE = 6,
    parameter int SNOOP_LAT   = 3,
    parameter int MAX_RETRY   = 3,
    parameter int TIMEOUT     = 15
) (
    input  logic          i_clk,
    input  logic          i_reset,
    l2_bus_ctrl_if.slave  io_bus
);

    localparam int CNT_W = 16;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_INVAL = 2'b10;
    localparam logic [1:0] OP_RWIM  = 2'b11;

    localparam logic [1:0] SN_NOHIT = 2'b00;
    localparam logic [1:0] SN_HIT   = 2'b01;
    localparam logic [1:0] SN_HITM  = 2'b10;

    localparam logic [CNT_W-1:0]    SNOOP_LAST = CNT_W'(SNOOP_LAT - 1);
    localparam logic [CNT_W-1:0]    DATA_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [7:0]          RETRY_MAX  = 8'(MAX_RETRY);
    localparam logic [ADD_SIZE-1:0] LINE_MASK  =
        {{(ADD_SIZE-OFFSET_SIZE){1'b1}}, {OFFSET_SIZE{1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_SNOOP = 3'd3,
        ST_DATA  = 3'd4,
        ST_RESP  = 3'd5
    } state_t;

    state_t              r_state;
    logic [1:0]          r_op;
    logic [ADD_SIZE-1:0] r_addr;
    logic [7:0]          r_attempts;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_hit;
    logic                r_hitm;
    logic                r_gap;
    logic [1:0]          r_merged;
    logic                r_req_ready;
    logic                r_resp_valid;
    logic [1:0]          r_resp_snoop;
    logic                r_resp_err;
    logic                r_bus_req;
    logic                r_bus_addr_valid;
    logic [1:0]          r_bus_op;
    logic [ADD_SIZE-1:0] r_bus_addr;
    logic [7:0]          r_retry_cnt;

    logic                w_hit_any;
    logic                w_hitm_any;
    logic                w_retry_op;
    logic [1:0]          w_merged;

    // Snoop merge including the current cycle, so the last window cycle counts.
    // Only consumed in SNOOP, which is what masks snoop inputs elsewhere.
    always_comb begin
        w_hit_any  = r_hit  | io_bus.snoop_hit;
        w_hitm_any = r_hitm | io_bus.snoop_hitm;
        w_retry_op = (r_op == OP_READ) || (r_op == OP_RWIM);
        if (w_hitm_any) begin
            w_merged = SN_HITM;
        end else if (w_hit_any) begin
            w_merged = SN_HIT;
        end else begin
            w_merged = SN_NOHIT;
        end
    end

    // Bus transaction FSM with all outputs registered alongside the state.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state          <= ST_IDLE;
            r_op             <= 2'b00;
            r_addr           <= '0;
            r_attempts       <= 8'd0;
            r_cnt            <= '0;
            r_hit            <= 1'b0;
            r_hitm           <= 1'b0;
            r_gap            <= 1'b0;
            r_merged         <= 2'b00;
            r_req_ready      <= 1'b1;
            r_resp_valid     <= 1'b0;
            r_resp_snoop     <= 2'b00;
            r_resp_err       <= 1'b0;
            r_bus_req        <= 1'b0;
            r_bus_addr_valid <= 1'b0;
            r_bus_op         <= 2'b00;
            r_bus_addr       <= '0;
            r_retry_cnt      <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (io_bus.req_valid) begin
                        r_op        <= io_bus.req_op;
                        r_addr      <= io_bus.req_addr & LINE_MASK;
                        r_attempts  <= 8'd0;
                        r_gap       <= 1'b0;
                        r_req_ready <= 1'b0;
                        r_bus_req   <= 1'b1;
                        r_state     <= ST_ARB;
                    end
                end

                ST_ARB: begin
                    // r_gap marks the one idle cycle after a HITM retry; any
                    // grant seen during it is not ours to take.
                    if (r_gap) begin
                        r_gap     <= 1'b0;
                        r_bus_req <= 1'b1;
                    end else if (io_bus.bus_gnt) begin
                        r_bus_addr_valid <= 1'b1;
                        r_bus_op         <= r_op;
                        r_bus_addr       <= r_addr;
                        r_hit            <= 1'b0;
                        r_hitm           <= 1'b0;
                        r_cnt            <= '0;
                        r_state          <= ST_ADDR;
                    end
                end

                ST_ADDR: begin
                    r_bus_addr_valid <= 1'b0;
                    r_bus_op         <= 2'b00;
                    r_bus_addr       <= '0;
                    r_state          <= ST_SNOOP;
                end

                ST_SNOOP: begin
                    r_hit  <= w_hit_any;
                    r_hitm <= w_hitm_any;
                    if (r_cnt == SNOOP_LAST) begin
                        r_cnt <= '0;
                        if (w_hitm_any && w_retry_op) begin
                            if (r_attempts < RETRY_MAX) begin
                                r_attempts <= r_attempts + 8'd1;
                                if (r_retry_cnt != 8'hFF) begin
                                    r_retry_cnt <= r_retry_cnt + 8'd1;
                                end
                                r_bus_req <= 1'b0;
                                r_gap     <= 1'b1;
                                r_state   <= ST_ARB;
                            end else begin
                                r_resp_valid <= 1'b1;
                                r_resp_snoop <= w_merged;
                                r_resp_err   <= 1'b1;
                                r_bus_req    <= 1'b0;
                                r_state      <= ST_RESP;
                            end
                        end else if (r_op == OP_INVAL) begin
                            r_resp_valid <= 1'b1;
                            r_resp_snoop <= w_merged;
                            r_resp_err   <= 1'b0;
                            r_bus_req    <= 1'b0;
                            r_state      <= ST_RESP;
                        end else begin
                            // Hold the snoop result back until the response
                            // so resp_snoop stays quiet during DATA.
                            r_merged <= w_merged;
                            r_state  <= ST_DATA;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                ST_DATA: begin
                    // Ack is tested first so an ack on the final cycle wins.
                    if (io_bus.mem_ack) begin
                        r_resp_valid <= 1'b1;
                        r_resp_snoop <= r_merged;
                        r_resp_err   <= 1'b0;
                        r_bus_req    <= 1'b0;
                        r_state      <= ST_RESP;
                    end else if (r_cnt == DATA_LAST) begin
                        r_resp_valid <= 1'b1;
                        r_resp_snoop <= r_merged;
                        r_resp_err   <= 1'b1;
                        r_bus_req    <= 1'b0;
                        r_state      <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                ST_RESP: begin
                    if (io_bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_resp_snoop <= 2'b00;
                        r_resp_err   <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end

                default: begin
                    r_state          <= ST_IDLE;
                    r_req_ready      <= 1'b1;
                    r_resp_valid     <= 1'b0;
                    r_resp_snoop     <= 2'b00;
                    r_resp_err       <= 1'b0;
                    r_bus_req        <= 1'b0;
                    r_bus_addr_valid <= 1'b0;
                    r_bus_op         <= 2'b00;
                    r_bus_addr       <= '0;
                end
            endcase
        end
    end

    assign io_bus.req_ready      = r_req_ready;
    assign io_bus.resp_valid     = r_resp_valid;
    assign io_bus.resp_snoop     = r_resp_snoop;
    assign io_bus.resp_err       = r_resp_err;
    assign io_bus.bus_req        = r_bus_req;
    assign io_bus.bus_addr_valid = r_bus_addr_valid;
    assign io_bus.bus_op         = r_bus_op;
    assign io_bus.bus_addr       = r_bus_addr;
    assign io_bus.retry_cnt      = r_retry_cnt;

endmodule
